// File: rtl/bytewrite_ram_port_ctrl.sv
// Initiator-side port controller for a write-first byte-write BRAM: request/response streams,
// a 3-entry response skid FIFO and a zero-fill clear engine.
module bytewrite_ram_port_ctrl #(
  parameter int unsigned SIZE          = 1024,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned COL_WIDTH     = 9,
  parameter int unsigned NB_COL        = 4,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  output logic                         busy,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_wr,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [NB_COL-1:0]            req_be,
  input  logic [NB_COL*COL_WIDTH-1:0]  req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [NB_COL*COL_WIDTH-1:0]  rsp_rdata,
  output logic [NB_COL-1:0]            ram_we,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic [NB_COL*COL_WIDTH-1:0]  ram_di,
  input  logic [NB_COL*COL_WIDTH-1:0]  ram_do
);

  localparam int unsigned W = NB_COL * COL_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(SIZE - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_pend_q, clr_pend_d;
  logic                  pend_q, pend_d;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [W-1:0]          fifo_q [3];

  logic accept;
  logic push;
  logic pop;
  logic credit_ok;

  // A pending read already owns a FIFO slot, so count it against the credit.
  assign credit_ok = ({1'b0, occ_q} + {2'b00, pend_q}) <= 3'd2;
  assign accept    = req_valid && req_ready;
  assign push      = pend_q;
  assign rsp_valid = (occ_q != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_rdata = fifo_q[rd_ptr_q];
  assign busy      = (state_q == StClear) || clr_pend_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_pend_d = clr_pend_q;
    req_ready  = 1'b0;
    ram_we     = '0;
    ram_addr   = req_addr;
    ram_di     = req_wdata;

    unique case (state_q)
      StClear: begin
        ram_we   = '1;
        ram_addr = cnt_q;
        ram_di   = '0;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      StRun: begin
        req_ready = !clr_pend_q && credit_ok;
        if (req_valid && req_ready && req_wr) begin
          ram_we = req_be;
        end
        if (clr) begin
          clr_pend_d = 1'b1;
        end
        // Outstanding responses drain before the sweep may overwrite anything.
        if (clr_pend_q && (occ_q == 2'd0) && !pend_q) begin
          state_d    = StClear;
          clr_pend_d = 1'b0;
        end
      end
      default: state_d = StRun;
    endcase

    if (rst) begin
      req_ready = 1'b0;
      ram_we    = '0;
    end
  end

  always_comb begin
    pend_d   = accept && !req_wr;
    occ_d    = occ_q + 2'(push) - 2'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_ON_RESET ? StClear : StRun;
      cnt_q      <= '0;
      clr_pend_q <= 1'b0;
      pend_q     <= 1'b0;
      occ_q      <= 2'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_pend_q <= clr_pend_d;
      pend_q     <= pend_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers and occupancy define what is live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_q[wr_ptr_q] <= ram_do;
    end
  end

endmodule

// File: tb/tb_bytewrite_ram_port_ctrl.sv
// Directed bench for bytewrite_ram_port_ctrl with a write-first byte-write BRAM model.
module tb_bytewrite_ram_port_ctrl;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        busy;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [9:0]  req_addr;
  logic [3:0]  req_be;
  logic [35:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [35:0] rsp_rdata;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [35:0] ram_di;
  logic [35:0] ram_do;

  int checks   = 0;
  int failures = 0;

  logic [35:0] mem [1024];

  bytewrite_ram_port_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .busy      (busy),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_be    (req_be),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di),
    .ram_do    (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] merge(input logic [35:0] old, input logic [3:0] we,
                                        input logic [35:0] di);
    logic [35:0] t;
    t = old;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) t[i*9 +: 9] = di[i*9 +: 9];
    end
    return t;
  endfunction

  // Write-first: read port shows the merged word in the same cycle as the write.
  always @(posedge clk) begin
    mem[ram_addr] <= merge(mem[ram_addr], ram_we, ram_di);
    ram_do        <= merge(mem[ram_addr], ram_we, ram_di);
  end

  function automatic logic [35:0] pat(input int i);
    return 36'(32'(i) * 32'd1237 + 32'd85);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [9:0] a, input logic [3:0] be,
                       input logic [35:0] d);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_be    = be;
    req_wdata = d;
    #1;
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [35:0] exp);
    drive(1'b0, a, 4'hF, '1);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_we"}, ram_we, 0);
    step();
    req_valid = 1'b0;
    #1;
    check({tag, "_lat1"}, rsp_valid, 0);
    step();
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_data"}, rsp_rdata, exp);
    step();
  endtask

  // Walks a busy period; counts sweep cycles, misplaced sweep writes and stray responses.
  task automatic sweep(output int n, output int bad, output int stale);
    int guard;
    n = 0; bad = 0; stale = 0; guard = 0;
    while (busy && guard < 3000) begin
      if (ram_we == 4'hF) begin
        if (ram_addr != 10'(n) || req_ready || ram_di != 36'h0) bad++;
        n++;
      end else if (n > 0) begin
        bad++;
      end
      if (rsp_valid) stale++;
      step();
      guard++;
    end
  endtask

  initial begin
    int n, bad, stale, acc, got, rdy_bad;
    logic [9:0] a;
    rst = 1'b1; clr = 1'b0; rsp_ready = 1'b1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    repeat (3) step();
    check("rst_ram_we", ram_we, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);

    // Power-on sweep
    rst = 1'b0;
    #1;
    check("init_busy", busy, 1);
    sweep(n, bad, stale);
    check("init_sweep_len", n, 1024);
    check("init_sweep_bad", bad, 0);
    check("init_done_busy", busy, 0);
    check("init_done_ready", req_ready, 1);
    read_check("rd5", 10'd5, 36'h0);

    // Byte-masked writes then read-after-write
    drive(1'b1, 10'h10, 4'hF, {9'h1AA, 9'h155, 9'h0F0, 9'h00F});
    check("wr_full_we", ram_we, 4'hF);
    check("wr_full_addr", ram_addr, 10'h10);
    check("wr_full_di", ram_di, {9'h1AA, 9'h155, 9'h0F0, 9'h00F});
    step();
    drive(1'b1, 10'h10, 4'b0100, {9'h000, 9'h1FF, 9'h000, 9'h000});
    check("wr_lane2_we", ram_we, 4'b0100);
    step();
    read_check("rd_merge", 10'h10, {9'h1AA, 9'h1FF, 9'h0F0, 9'h00F});

    // Back-to-back reads at full rate
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10'(i), 4'hF, pat(i));
      step();
    end
    rdy_bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        drive(1'b0, 10'(k), 4'h0, '0);
        if (!req_ready) rdy_bad++;
      end else begin
        req_valid = 1'b0;
        #1;
      end
      if (k == 1) check("seq_lat", rsp_valid, 0);
      if (k >= 2) begin
        check("seq_valid", rsp_valid, 1);
        check("seq_data", rsp_rdata, pat(k - 2));
      end
      step();
    end
    check("seq_ready_held", rdy_bad, 0);
    check("seq_end", rsp_valid, 0);

    // Backpressure: credit limits to 3 outstanding
    rsp_ready = 1'b0;
    acc = 0;
    a = 10'd0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, a, 4'h0, '0);
      if (req_ready) begin
        acc++;
        a = a + 10'd1;
      end
      step();
    end
    req_valid = 1'b0;
    #1;
    check("bp_accepts", acc, 3);
    check("bp_ready_low", req_ready, 0);
    check("bp_head_valid", rsp_valid, 1);
    check("bp_head_data", rsp_rdata, pat(0));
    rsp_ready = 1'b1;
    #1;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) begin
        check("bp_rsp", rsp_rdata, pat(got));
        got++;
      end
      step();
    end
    check("bp_count", got, 3);
    check("bp_ready_back", req_ready, 1);

    // Clear with responses held
    rsp_ready = 1'b0;
    drive(1'b0, 10'h10, 4'h0, '0);
    step();
    drive(1'b0, 10'd1, 4'h0, '0);
    step();
    req_valid = 1'b0;
    step();
    clr = 1'b1;
    #1;
    step();
    clr = 1'b0;
    #1;
    check("clr_busy", busy, 1);
    check("clr_ready_low", req_ready, 0);
    step();
    step();
    check("clr_wait_we", ram_we, 0);
    check("clr_wait_busy", busy, 1);
    check("clr_wait_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    #1;
    check("clr_rsp0", rsp_rdata, {9'h1AA, 9'h1FF, 9'h0F0, 9'h00F});
    step();
    check("clr_rsp1_valid", rsp_valid, 1);
    check("clr_rsp1", rsp_rdata, pat(1));
    step();
    sweep(n, bad, stale);
    check("clr_sweep_len", n, 1024);
    check("clr_sweep_bad", bad, 0);
    check("clr_sweep_stale", stale, 0);
    read_check("rd_after_clr", 10'h10, 36'h0);

    // Reset mid-flight
    drive(1'b1, 10'd3, 4'hF, pat(9));
    step();
    rsp_ready = 1'b0;
    drive(1'b0, 10'd3, 4'h0, '0);
    step();
    drive(1'b0, 10'd4, 4'h0, '0);
    step();
    req_valid = 1'b0;
    #1;
    check("rstm_valid", rsp_valid, 1);
    check("rstm_data", rsp_rdata, pat(9));
    rst = 1'b1;
    #1;
    check("rstm_we", ram_we, 0);
    step();
    check("rstm_drop", rsp_valid, 0);
    check("rstm_ready", req_ready, 0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("rstm_addr0", ram_addr, 0);
    check("rstm_we_on", ram_we, 4'hF);
    sweep(n, bad, stale);
    check("rstm_sweep_len", n, 1024);
    check("rstm_sweep_bad", bad, 0);
    check("rstm_stale", stale, 0);
    repeat (3) step();
    check("rstm_final_valid", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bytewrite_ram_port_ctrl.md
Name: bytewrite_ram_port_ctrl

Overview:
- Initiator-side controller for the team's single-port byte-write BRAM (write-first, 1-cycle read latency).
- Converts a valid/ready request stream (read, or byte-masked write) into RAM port cycles.
- Returns read data on a valid/ready response stream through a 3-entry skid FIFO.
- Contains a clear engine that zero-fills the whole RAM after reset or on command.

Parameters:
SIZE, 1024, number of RAM words
ADDR_WIDTH, 10, address width; SIZE <= 2**ADDR_WIDTH
COL_WIDTH, 9, bits per byte lane
NB_COL, 4, number of byte lanes; word width W = NB_COL*COL_WIDTH
INIT_ON_RESET, 1, 1 = run a clear sweep after reset; 0 = go straight to RUN

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
clr  in  1  request a zero-fill sweep (single-cycle pulse)
busy  out  1  high while a sweep is pending or running
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready at posedge
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_be  in  NB_COL  per-lane write enable; ignored for reads
req_wdata  in  W  write data, lane i = bits [(i+1)*COL_WIDTH-1 : i*COL_WIDTH]
rsp_valid  out  1  read data valid
rsp_ready  in  1  response consumer ready
rsp_rdata  out  W  read data
ram_we  out  NB_COL  to RAM byte write enables
ram_addr  out  ADDR_WIDTH  to RAM address
ram_di  out  W  to RAM write data
ram_do  in  W  from RAM read data, valid 1 cycle after address sampled

Behaviour:
- Reset (rst=1 at posedge):
  - rsp_valid=0; FIFO occupancy=0; read-pending flag=0; clr_pend=0; sweep counter=0.
  - State=CLEAR if INIT_ON_RESET=1, else RUN.
  - In-flight reads and queued responses are discarded; no response is produced for them.
  - While rst=1, ram_we=0 and req_ready=0.
- States:
  - CLEAR: each cycle ram_we=all ones, ram_di=0, ram_addr=counter; counter increments. After the cycle with counter==SIZE-1, counter returns to 0 and state becomes RUN. Duration is exactly SIZE cycles. busy=1, req_ready=0.
  - RUN: req_ready = !clr_pend && (occ + pend <= 2). req_ready never depends on req_valid or payload. busy=clr_pend.
- RAM drive in RUN (combinational from the request):
  - ram_addr=req_addr; ram_di=req_wdata.
  - ram_we = req_be when the accept is a write; ram_we=0 in every other case.
  - ram_addr and ram_di are don't-care when nothing is accepted.
- Read path:
  - Read accepted at edge N: pend=1 after N; ram_do is captured into the FIFO at edge N+1; rsp_valid=1 after N+1. Latency is 2 cycles.
  - One read per cycle is sustained when rsp_ready=1.
  - FIFO depth 3. push = pend; pop = rsp_valid && rsp_ready. Simultaneous push and pop leaves occ unchanged.
  - rsp_rdata is driven from the FIFO head and stays stable while rsp_valid && !rsp_ready.
  - Responses are returned in request order.
  - The credit rule (occ + pend <= 2) makes overflow impossible.
- Writes:
  - Posted; no response.
  - Lanes with req_be[i]=0 are unchanged in the RAM.
  - A read issued in the cycle after a write to the same address returns the new data.
- clr:
  - In RUN, sets clr_pend and req_ready drops the next cycle.
  - Enter CLEAR once occ==0 && pend==0 && !(rsp_valid); pending responses drain first.
  - clr in CLEAR is ignored; clr with rst: rst wins.

Test Plan:
- INIT_ON_RESET=1, release rst -> busy=1 and req_ready=0 for exactly 1024 cycles, ram_we=4'hF with addr 0..1023; then read addr 5 -> rsp_rdata=0 two cycles after accept.
- Write addr 0x10, be=4'b1111, lanes{3..0}={0x1AA,0x155,0x0F0,0x00F}; then write be=4'b0100 with lane2=0x1FF; then read 0x10 -> {0x1AA,0x1FF,0x0F0,0x00F}.
- Reads addr 0..7 back-to-back with rsp_ready=1 -> req_ready stays 1; 8 consecutive rsp_valid cycles starting 2 cycles after the first accept, data in address order.
- rsp_ready=0, continuous reads -> exactly 3 accepted, then req_ready=0; raise rsp_ready -> 3 responses in order, no loss or duplication, and req_ready returns.
- Hold 2 responses with rsp_ready=0, pulse clr -> busy=1 immediately and no sweep yet; raise rsp_ready -> both responses delivered, then 1024-cycle sweep; a subsequent read of a previously written address returns 0.
- Assert rst while rsp_valid=1 and a read is pending -> rsp_valid=0 after that edge, no stale response afterwards, and a CLEAR sweep restarts from addr 0.
